spi_master_param: RTL and testbench

SPI_MASTER_PARAM -- requirements
Module: spi_master_param

---
 rtl/spi_master_param.sv | 175 +++++++++++++++++
 tb/tb_spi_master_param.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_param.sv
// Parameterised SPI master: one frame of DATA_W bits, runtime CPOL/CPHA/bit order.
// Optional macro SPI_MASTER_PARAM_LOOPBACK_EN adds loopback_i (receive path samples mosi_o).
module spi_master_param #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4
) (
  input  logic              clk_i,
  input  logic              aresetn_i,
  input  logic              start_i,
  input  logic              cpol_i,
  input  logic              cpha_i,
  input  logic              lsb_first_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              miso_i,
`ifdef SPI_MASTER_PARAM_LOOPBACK_EN
  input  logic              loopback_i,
`endif
  output logic              ready_o,
  output logic              done_o,
  output logic [DATA_W-1:0] data_o,
  output logic              sclk_o,
  output logic              mosi_o,
  output logic              cs_n_o
);

  localparam int DIV_W  = $clog2(CLK_DIV + 1);
  localparam int EDGE_W = $clog2(2 * DATA_W + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W - 1);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, DONE} state_t;

  state_t              state_reg;
  logic [DIV_W-1:0]    div_cnt_reg;
  logic [EDGE_W-1:0]   edge_cnt_reg;
  logic [DATA_W-1:0]   tx_reg;
  logic [DATA_W-1:0]   rx_reg;
  logic                cpol_reg;
  logic                cpha_reg;
  logic                lsb_reg;
  logic                ready_reg;
  logic                done_reg;
  logic [DATA_W-1:0]   data_reg;
  logic                sclk_reg;
  logic                mosi_reg;
  logic                cs_n_reg;

  logic                rx_bit;
  logic                div_hit;
  logic                last_edge;
  logic                sample_now;
  logic                tx_bit;
  logic [DATA_W-1:0]   tx_next;
  logic [DATA_W-1:0]   rx_next;
  logic                first_bit;
  logic [DATA_W-1:0]   first_rest;

`ifdef SPI_MASTER_PARAM_LOOPBACK_EN
  assign rx_bit = loopback_i ? mosi_reg : miso_i;
`else
  assign rx_bit = miso_i;
`endif

  assign div_hit   = (div_cnt_reg == DIV_LAST);
  assign last_edge = (edge_cnt_reg == EDGE_LAST);
  // Even edge counts are leading edges; cpha selects which edge samples.
  assign sample_now = (~edge_cnt_reg[0]) ^ cpha_reg;

  assign tx_bit  = lsb_reg ? tx_reg[0] : tx_reg[DATA_W-1];
  assign tx_next = lsb_reg ? (tx_reg >> 1) : (tx_reg << 1);
  assign rx_next = lsb_reg ? {rx_bit, rx_reg[DATA_W-1:1]} : {rx_reg[DATA_W-2:0], rx_bit};

  assign first_bit  = lsb_first_i ? data_i[0] : data_i[DATA_W-1];
  assign first_rest = lsb_first_i ? (data_i >> 1) : (data_i << 1);

  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      state_reg    <= IDLE;
      div_cnt_reg  <= '0;
      edge_cnt_reg <= '0;
      tx_reg       <= '0;
      rx_reg       <= '0;
      cpol_reg     <= 1'b0;
      cpha_reg     <= 1'b0;
      lsb_reg      <= 1'b0;
      ready_reg    <= 1'b1;
      done_reg     <= 1'b0;
      data_reg     <= '0;
      sclk_reg     <= 1'b0;
      mosi_reg     <= 1'b0;
      cs_n_reg     <= 1'b1;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          ready_reg <= 1'b1;
          cs_n_reg  <= 1'b1;
          sclk_reg  <= cpol_i;
          mosi_reg  <= 1'b0;
          if (start_i) begin
            state_reg    <= SETUP;
            ready_reg    <= 1'b0;
            cs_n_reg     <= 1'b0;
            cpol_reg     <= cpol_i;
            cpha_reg     <= cpha_i;
            lsb_reg      <= lsb_first_i;
            div_cnt_reg  <= '0;
            edge_cnt_reg <= '0;
            rx_reg       <= '0;
            // cpha=0 needs the first bit on the wire before the first leading edge.
            if (!cpha_i) begin
              mosi_reg <= first_bit;
              tx_reg   <= first_rest;
            end else begin
              tx_reg   <= data_i;
            end
          end
        end
        SETUP: begin
          if (div_hit) begin
            state_reg   <= XFER;
            div_cnt_reg <= '0;
            sclk_reg    <= cpol_reg;
          end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
          end
        end
        XFER: begin
          if (div_hit) begin
            div_cnt_reg  <= '0;
            sclk_reg     <= ~sclk_reg;
            edge_cnt_reg <= edge_cnt_reg + 1'b1;
            if (sample_now) begin
              rx_reg <= rx_next;
            end else if (!last_edge) begin
              mosi_reg <= tx_bit;
              tx_reg   <= tx_next;
            end
            if (last_edge) begin
              state_reg <= HOLD;
            end
          end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
          end
        end
        HOLD: begin
          if (div_hit) begin
            state_reg   <= DONE;
            div_cnt_reg <= '0;
            done_reg    <= 1'b1;
            data_reg    <= rx_reg;
          end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          ready_reg <= 1'b1;
          cs_n_reg  <= 1'b1;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign ready_o = ready_reg;
  assign done_o  = done_reg;
  assign data_o  = data_reg;
  assign sclk_o  = sclk_reg;
  assign mosi_o  = mosi_reg;
  assign cs_n_o  = cs_n_reg;

endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench for spi_master_param: 8-bit/CLK_DIV=2 instance plus a 32-bit/CLK_DIV=1 instance.
module tb_spi_master_param;

  localparam int LAT_A = (2 * 8 + 2) * 2;
  localparam int LAT_B = (2 * 32 + 2) * 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic aresetn;

  logic       start_a, cpol_a, cpha_a, lsb_a, miso_a;
  logic [7:0] data_in_a, data_out_a;
  logic       ready_a, done_a, sclk_a, mosi_a, cs_n_a;

  logic        start_b, cpol_b, cpha_b, lsb_b, miso_b;
  logic [31:0] data_in_b, data_out_b;
  logic        ready_b, done_b, sclk_b, mosi_b, cs_n_b;

  int n_vec = 0;
  int n_err = 0;

  // sclk edge counter and mosi capture at the sampling edge
  logic        mon_pos = 1'b1;
  int          mon_edges = 0;
  logic [31:0] mon_seq = '0;
  int          edge_base;

  always @(sclk_a) begin
    if (cs_n_a === 1'b0) begin
      mon_edges++;
      if (sclk_a == mon_pos) mon_seq = {mon_seq[30:0], mosi_a};
    end
  end

  // slave model: presents slave_word LSB-first on each falling (leading, cpol=1) edge
  logic       slave_on = 1'b0;
  logic [7:0] slave_word = '0;
  logic       miso_slave = 1'b0;
  int         slave_cnt = 0;
  int         slave_base = 0;

  always @(negedge sclk_a) begin
    if (slave_on) miso_slave = slave_word[3'(slave_cnt - slave_base)];
    slave_cnt++;
  end

  assign miso_a = slave_on ? miso_slave : mosi_a;

  spi_master_param #(.DATA_W(8), .CLK_DIV(2)) u_dut_a (
    .clk_i       (clk),
    .aresetn_i   (aresetn),
    .start_i     (start_a),
    .cpol_i      (cpol_a),
    .cpha_i      (cpha_a),
    .lsb_first_i (lsb_a),
    .data_i      (data_in_a),
    .miso_i      (miso_a),
`ifdef SPI_MASTER_PARAM_LOOPBACK_EN
    .loopback_i  (1'b0),
`endif
    .ready_o     (ready_a),
    .done_o      (done_a),
    .data_o      (data_out_a),
    .sclk_o      (sclk_a),
    .mosi_o      (mosi_a),
    .cs_n_o      (cs_n_a)
  );

`ifdef SPI_MASTER_PARAM_LOOPBACK_EN
  assign miso_b = 1'b0;
`else
  assign miso_b = mosi_b;
`endif

  spi_master_param #(.DATA_W(32), .CLK_DIV(1)) u_dut_b (
    .clk_i       (clk),
    .aresetn_i   (aresetn),
    .start_i     (start_b),
    .cpol_i      (cpol_b),
    .cpha_i      (cpha_b),
    .lsb_first_i (lsb_b),
    .data_i      (data_in_b),
    .miso_i      (miso_b),
`ifdef SPI_MASTER_PARAM_LOOPBACK_EN
    .loopback_i  (1'b1),
`endif
    .ready_o     (ready_b),
    .done_o      (done_b),
    .data_o      (data_out_b),
    .sclk_o      (sclk_b),
    .mosi_o      (mosi_b),
    .cs_n_o      (cs_n_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a start on DUT A; returns at the sample point of the first cycle after acceptance.
  task automatic launch_a(input logic cpol, input logic cpha, input logic lsb, input logic [7:0] d);
    cpol_a    = cpol;
    cpha_a    = cpha;
    lsb_a     = lsb;
    data_in_a = d;
    mon_pos   = ~(cpol ^ cpha);
    edge_base = mon_edges;
    start_a   = 1'b1;
    @(posedge clk); #1;
    start_a   = 1'b0;
  endtask

  // Walks one frame from the first post-acceptance cycle to the first IDLE cycle.
  task automatic wait_frame_a(input string name, input logic [7:0] exp_data,
                              input logic [7:0] prev_data, input int poke_k);
    for (int k = 0; k <= LAT_A; k++) begin
      if (poke_k >= 0 && k == poke_k) begin
        start_a   = 1'b1;
        data_in_a = 8'h00;
      end
      if (poke_k >= 0 && k == poke_k + 1) start_a = 1'b0;
      chk($sformatf("%s_done_k%0d", name, k), 32'(done_a), 32'(k == LAT_A));
      if (k == 0) begin
        chk({name, "_cs_low"}, 32'(cs_n_a), 32'd0);
        chk({name, "_busy"}, 32'(ready_a), 32'd0);
      end
      if (k == LAT_A - 1) chk({name, "_data_hold"}, 32'(data_out_a), 32'(prev_data));
      if (k == LAT_A) begin
        chk({name, "_data"}, 32'(data_out_a), 32'(exp_data));
        chk({name, "_cs_in_done"}, 32'(cs_n_a), 32'd0);
      end
      @(posedge clk); #1;
    end
    chk({name, "_done_drop"}, 32'(done_a), 32'd0);
    chk({name, "_ready_back"}, 32'(ready_a), 32'd1);
    chk({name, "_cs_high"}, 32'(cs_n_a), 32'd1);
    $display("frame %s: data_o=%02h expected %02h", name, data_out_a, exp_data);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn = 1'b1;
    start_a = 1'b0; cpol_a = 1'b0; cpha_a = 1'b0; lsb_a = 1'b0; data_in_a = '0;
    start_b = 1'b0; cpol_b = 1'b0; cpha_b = 1'b0; lsb_b = 1'b0; data_in_b = '0;
    #2 aresetn = 1'b0;
    #1;
    chk("rst_ready", 32'(ready_a), 32'd1);
    chk("rst_done",  32'(done_a),  32'd0);
    chk("rst_data",  32'(data_out_a), 32'd0);
    chk("rst_sclk",  32'(sclk_a),  32'd0);
    chk("rst_mosi",  32'(mosi_a),  32'd0);
    chk("rst_cs_n",  32'(cs_n_a),  32'd1);
    repeat (2) @(posedge clk);
    #1;
    aresetn = 1'b1;

    // Mode 0 MSB-first 0xA5, accepted on the first edge after reset release.
    launch_a(1'b0, 1'b0, 1'b0, 8'hA5);
    wait_frame_a("m0_a5", 8'hA5, 8'h00, -1);
    chk("m0_a5_mosi_seq", mon_seq[7:0], 32'hA5);
    chk("m0_a5_edges", 32'(mon_edges - edge_base), 32'd16);

    // Mode 3 LSB-first: idle level follows live cpol_i, slave returns 0x81.
    cpol_a = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_sclk_hi", 32'(sclk_a), 32'd1);
    chk("idle_mosi_lo", 32'(mosi_a), 32'd0);
    slave_word = 8'h81;
    slave_base = slave_cnt;
    slave_on   = 1'b1;
    launch_a(1'b1, 1'b1, 1'b1, 8'h3C);
    wait_frame_a("m3_3c", 8'h81, 8'hA5, -1);
    chk("m3_3c_mosi_seq", mon_seq[7:0], 32'h3C);
    chk("m3_3c_edges", 32'(mon_edges - edge_base), 32'd16);
    chk("m3_3c_sclk_idle", 32'(sclk_a), 32'd1);

    // Mode 3 LSB-first with non-symmetric words to pin down bit order.
    slave_word = 8'h8E;
    slave_base = slave_cnt;
    launch_a(1'b1, 1'b1, 1'b1, 8'h4B);
    wait_frame_a("m3_4b", 8'h8E, 8'h81, -1);
    chk("m3_4b_mosi_seq", mon_seq[7:0], 32'hD2);
    slave_on = 1'b0;
    cpol_a   = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Mode 0 LSB-first 0x13 looped back externally.
    launch_a(1'b0, 1'b0, 1'b1, 8'h13);
    wait_frame_a("m0_13_lsb", 8'h13, 8'h8E, -1);
    chk("m0_13_mosi_seq", mon_seq[7:0], 32'hC8);

    // Back-to-back frames with start_i held high.
    cpol_a = 1'b0; cpha_a = 1'b0; lsb_a = 1'b0;
    data_in_a = 8'h01;
    start_a   = 1'b1;
    @(posedge clk); #1;
    data_in_a = 8'hFE;
    wait_frame_a("b2b_01", 8'h01, 8'h13, -1);
    @(posedge clk); #1;
    start_a = 1'b0;
    wait_frame_a("b2b_fe", 8'hFE, 8'h01, -1);

    // start_i pulsed mid-XFER with different data is ignored.
    launch_a(1'b0, 1'b0, 1'b0, 8'h5A);
    wait_frame_a("ign_5a", 8'h5A, 8'hFE, 12);
    @(posedge clk); #1;
    chk("ign_no_queue_ready", 32'(ready_a), 32'd1);
    chk("ign_no_queue_cs", 32'(cs_n_a), 32'd1);

    // Reset at sclk edge 7 aborts the frame.
    launch_a(1'b0, 1'b0, 1'b0, 8'h77);
    for (int i = 0; i < 200 && (mon_edges - edge_base) < 7; i++) begin
      @(posedge clk); #1;
    end
    chk("abort_edge7_reached", 32'((mon_edges - edge_base) >= 7), 32'd1);
    aresetn = 1'b0;
    #1;
    chk("abort_cs_n", 32'(cs_n_a), 32'd1);
    chk("abort_data", 32'(data_out_a), 32'd0);
    chk("abort_done", 32'(done_a), 32'd0);
    chk("abort_ready", 32'(ready_a), 32'd1);
    @(posedge clk); #1;
    chk("abort_done_hold", 32'(done_a), 32'd0);
    aresetn = 1'b1;
    launch_a(1'b0, 1'b0, 1'b0, 8'h96);
    wait_frame_a("post_rst_96", 8'h96, 8'h00, -1);
    chk("post_rst_mosi_seq", mon_seq[7:0], 32'h96);

    // 32-bit frame, CLK_DIV=1, mode 1, loopback.
    cpol_b = 1'b0; cpha_b = 1'b1; lsb_b = 1'b0;
    data_in_b = 32'hDEADBEEF;
    start_b   = 1'b1;
    @(posedge clk); #1;
    start_b   = 1'b0;
    for (int k = 0; k <= LAT_B; k++) begin
      chk($sformatf("w32_done_k%0d", k), 32'(done_b), 32'(k == LAT_B));
      if (k == LAT_B) chk("w32_data", data_out_b, 32'hDEADBEEF);
      @(posedge clk); #1;
    end
    chk("w32_ready_back", 32'(ready_b), 32'd1);
    chk("w32_cs_high", 32'(cs_n_b), 32'd1);
    $display("frame w32_deadbeef: data_o=%08h expected deadbeef", data_out_b);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
